x_wrr_arbiter: RTL

Parametrised weighted round-robin row arbiter for the event-based camera readout. It is the successor to the fixed-width row round-robin: width is generic, each requester has a programmable grant weight, and every grant is held until a consumer acknowledge arrives. It sits between the pixel-array row request lines and the row readout / address encoder. It issues one registered one-hot grant plus its binary index at a time.

---
 rtl/x_wrr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/x_wrr_arbiter.sv
// Weighted round-robin row arbiter: one registered one-hot grant at a time, held until the
// consumer acknowledges or the winning request drops.
module x_wrr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned X_WIDTH  = $clog2(WIDTH),
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [WIDTH-1:0]          req_i,
  input  logic [WIDTH*WEIGHT_W-1:0] weight_i,
  input  logic                      ack_i,
  output logic [WIDTH-1:0]          x_gnt_o,
  output logic [X_WIDTH-1:0]        xadd_o,
  output logic                      valid_o
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [X_WIDTH-1:0]    ptr_q, ptr_d;
  logic [X_WIDTH-1:0]    win_q, win_d;
  logic [X_WIDTH-1:0]    xadd_q, xadd_d;
  logic [WEIGHT_W-1:0]   used_q, used_d;
  logic [WEIGHT_W-1:0]   wt_q, wt_d;
  logic [WIDTH-1:0]      gnt_q, gnt_d;
  logic                  valid_q, valid_d;

  logic [WIDTH-1:0]      rot;
  logic [X_WIDTH:0]      sum;
  logic [X_WIDTH-1:0]    pick;
  logic [WEIGHT_W-1:0]   w_sel;
  logic [X_WIDTH-1:0]    ptr_adv;
  logic                  keep;

  // Rotate requests so bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    rot  = WIDTH'({req_i, req_i} >> ptr_q);
    sum  = '0;
    pick = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr_q} + (X_WIDTH + 1)'(i);
        if (sum >= (X_WIDTH + 1)'(WIDTH)) begin
          sum = sum - (X_WIDTH + 1)'(WIDTH);
        end
        pick = sum[X_WIDTH-1:0];
      end
    end
  end

  assign w_sel   = WEIGHT_W'(weight_i >> (pick * WEIGHT_W));
  assign ptr_adv = (win_q == X_WIDTH'(WIDTH - 1)) ? '0 : win_q + 1'b1;
  // Winner keeps priority only while it still requests and has credit left.
  assign keep    = ack_i && req_i[win_q] && (({1'b0, used_q} + 1'b1) < {1'b0, wt_q});

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    xadd_d  = xadd_q;
    used_d  = used_q;
    wt_d    = wt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i && |req_i) begin
          state_d = StGrant;
          win_d   = pick;
          wt_d    = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;
          gnt_d   = WIDTH'(1) << pick;
          xadd_d  = pick;
          valid_d = 1'b1;
        end
      end
      StGrant: begin
        if (ack_i || !req_i[win_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          xadd_d  = '0;
          valid_d = 1'b0;
          if (keep) begin
            used_d = used_q + 1'b1;
            ptr_d  = win_q;
          end else begin
            used_d = '0;
            ptr_d  = ptr_adv;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      xadd_q  <= '0;
      used_q  <= '0;
      wt_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      xadd_q  <= xadd_d;
      used_q  <= used_d;
      wt_q    <= wt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign x_gnt_o = gnt_q;
  assign xadd_o  = xadd_q;
  assign valid_o = valid_q;

endmodule
